// File: rtl/gray_bus_pkg.sv
// Shared types and helpers for the Gray-coded bus update scheduler.
// The Gray conversion is written once at the widest supported bus and narrowed by callers.
package gray_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int MIN_HOLD_CYCLES = 1;
  localparam int MIN_PENDING     = 1;
  localparam int MAX_BUS_WIDTH   = 64;

  function automatic logic [MAX_BUS_WIDTH-1:0] bin2gray(input logic [MAX_BUS_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_bus_update_scheduler_binary_to_gray.sv
// Combinational binary-to-Gray converter of configurable width.
module binary_to_gray
  import gray_bus_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(MAX_BUS_WIDTH'(bin)));

endmodule

// File: rtl/gray_bus_update_scheduler.sv
// Source-side pacer for a multi-flop Gray bus crossing: queues increment requests and
// advances the Gray bus no faster than once every HOLD_CYCLES clocks.
module gray_bus_update_scheduler
  import gray_bus_pkg::*;
#(
  parameter  int BUS_WIDTH     = 4,
  parameter  int HOLD_CYCLES   = 3,
  parameter  int MAX_PENDING   = 4,
  localparam int PENDING_WIDTH = $clog2(MAX_PENDING + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc_valid,
  output logic                     inc_ready,
  output logic [BUS_WIDTH-1:0]     gray_out,
  output logic [BUS_WIDTH-1:0]     binary_count,
  output logic                     update_strobe,
  output logic [PENDING_WIDTH-1:0] pending_count,
  output logic                     busy
);

  if (HOLD_CYCLES < MIN_HOLD_CYCLES || MAX_PENDING < MIN_PENDING ||
      BUS_WIDTH < 1 || BUS_WIDTH > MAX_BUS_WIDTH) begin : g_bad_params
    $error("gray_bus_update_scheduler: illegal parameter combination");
  end

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]        HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX  = PENDING_WIDTH'(MAX_PENDING);
  localparam logic [PENDING_WIDTH-1:0] PEND_ONE  = PENDING_WIDTH'(1);

  state_t                   state, state_next;
  logic [HOLD_W-1:0]        hold_cnt, hold_next;
  logic [PENDING_WIDTH-1:0] pending_next;
  logic [BUS_WIDTH-1:0]     bin_next, gray_next;
  logic                     accept, issue;

  assign accept   = inc_valid && inc_ready;
  assign issue    = (hold_cnt == '0) && (pending_count != '0);
  assign bin_next = binary_count + BUS_WIDTH'(1);

  binary_to_gray #(.WIDTH(BUS_WIDTH)) u_binary_to_gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // NOTE: every signal gets a default before any branch so always_comb never infers a latch.
  always_comb begin
    hold_next    = hold_cnt;
    pending_next = pending_count;
    if (issue)                hold_next = HOLD_LOAD;
    else if (hold_cnt != '0)  hold_next = hold_cnt - HOLD_W'(1);
    if (accept && !issue)     pending_next = pending_count + PEND_ONE;
    else if (!accept && issue) pending_next = pending_count - PEND_ONE;
  end

  // State tracks the upcoming hold count so busy drops on the edge the hold expires.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (hold_next != '0) state_next = HOLD;
      HOLD:    if (hold_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and the reset is sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      pending_count <= '0;
      binary_count  <= '0;
      gray_out      <= '0;
      update_strobe <= 1'b0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_next;
      pending_count <= pending_next;
      update_strobe <= issue;
      if (issue) begin
        binary_count <= bin_next;
        gray_out     <= gray_next;
      end
    end
  end

  always_comb begin
    inc_ready = (pending_count < PEND_MAX);
    busy      = (state == HOLD) || (pending_count != '0);
  end

endmodule

// File: tb/tb_gray_bus_update_scheduler.sv
// Self-checking bench: vector table for single/burst traffic, hand sequences for
// backpressure, wrap-around and mid-operation reset, and a scoreboard on every bus update.
module tb_gray_bus_update_scheduler;

  logic       clk;
  logic       reset;
  logic       inc_valid;
  logic       inc_ready;
  logic [3:0] gray_out;
  logic [3:0] binary_count;
  logic       update_strobe;
  logic [2:0] pending_count;
  logic       busy;

  gray_bus_update_scheduler #(
    .BUS_WIDTH   (4),
    .HOLD_CYCLES (3),
    .MAX_PENDING (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inc_valid     (inc_valid),
    .inc_ready     (inc_ready),
    .gray_out      (gray_out),
    .binary_count  (binary_count),
    .update_strobe (update_strobe),
    .pending_count (pending_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [3:0]  exp_q[$];
  logic [3:0]  model_bin = '0;
  logic [3:0]  prev_gray = '0;
  logic [3:0]  sb_b;
  int unsigned acc_cnt = 0, iss_cnt = 0, cyc = 0, last_upd_cyc = 0;
  bit          have_upd = 0;
  bit          mon_en = 0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      exp_q.delete();
      model_bin = '0;
      prev_gray = '0;
      acc_cnt   = 0;
      iss_cnt   = 0;
      have_upd  = 0;
    end else if (inc_valid && inc_ready) begin
      model_bin = model_bin + 4'd1;
      exp_q.push_back(model_bin);
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (update_strobe) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_update", 32'(gray_out), 32'(prev_gray));
        end else begin
          sb_b = exp_q.pop_front();
          check("sb_gray", 32'(gray_out), 32'(sb_b ^ (sb_b >> 1)));
          check("sb_binary", 32'(binary_count), 32'(sb_b));
        end
        check("one_bit_change", 32'($countones(gray_out ^ prev_gray)), 32'd1);
        if (have_upd) check("spacing_ge_3", 32'((cyc - last_upd_cyc) >= 3), 32'd1);
        iss_cnt++;
        have_upd     = 1;
        last_upd_cyc = cyc;
        prev_gray    = gray_out;
      end
      check("sb_balance", 32'(iss_cnt + 32'(pending_count)), 32'(acc_cnt));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input logic v, input logic rst_n);
    inc_valid = v;
    reset     = rst_n;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 100) begin
      tick(1'b0, 1'b1);
      n++;
    end
    check("drain_done", 32'(busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] gray;
    logic [2:0] pend;
    logic       strobe;
    logic       ready;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [3:0] g, input logic [2:0] p,
                     input logic s, input logic rd, input logic b);
    vec_t t;
    t.rst = r; t.vld = v; t.gray = g; t.pend = p; t.strobe = s; t.ready = rd; t.busy = b;
    vecs.push_back(t);
  endtask

  initial begin
    int          acc;
    int          n;
    int          exp_p[9];
    logic        exp_r[9];
    logic [9:0]  act_v, exp_v;

    reset     = 1'b0;
    inc_valid = 1'b0;

    // Reset defaults, then a single request.
    add(1, 1, 4'h0, 3'd0, 0, 1, 0);
    add(1, 0, 4'h0, 3'd0, 0, 1, 0);
    add(0, 1, 4'h0, 3'd1, 0, 1, 1);
    add(0, 0, 4'h1, 3'd0, 1, 1, 1);
    add(0, 0, 4'h1, 3'd0, 0, 1, 1);
    add(0, 0, 4'h1, 3'd0, 0, 1, 0);
    // Burst of four after a fresh reset.
    add(1, 0, 4'h0, 3'd0, 0, 1, 0);
    add(0, 1, 4'h0, 3'd1, 0, 1, 1);
    add(0, 1, 4'h1, 3'd1, 1, 1, 1);
    add(0, 1, 4'h1, 3'd2, 0, 1, 1);
    add(0, 1, 4'h1, 3'd3, 0, 1, 1);
    add(0, 0, 4'h3, 3'd2, 1, 1, 1);
    add(0, 0, 4'h3, 3'd2, 0, 1, 1);
    add(0, 0, 4'h3, 3'd2, 0, 1, 1);
    add(0, 0, 4'h2, 3'd1, 1, 1, 1);
    add(0, 0, 4'h2, 3'd1, 0, 1, 1);
    add(0, 0, 4'h2, 3'd1, 0, 1, 1);
    add(0, 0, 4'h6, 3'd0, 1, 1, 1);
    add(0, 0, 4'h6, 3'd0, 0, 1, 1);
    add(0, 0, 4'h6, 3'd0, 0, 1, 0);

    foreach (vecs[i]) begin
      tick(vecs[i].vld, ~vecs[i].rst);
      mon_en = 1;
      act_v = {gray_out, pending_count, update_strobe, inc_ready, busy};
      exp_v = {vecs[i].gray, vecs[i].pend, vecs[i].strobe, vecs[i].ready, vecs[i].busy};
      check($sformatf("vec%0d{gray,pend,strobe,ready,busy}", i), 32'(act_v), 32'(exp_v));
    end

    // Backpressure: inc_valid held high.
    tick(1'b0, 1'b0);
    exp_p = '{1, 1, 2, 3, 3, 4, 4, 3, 4};
    exp_r = '{1, 1, 1, 1, 1, 0, 0, 1, 0};
    for (int e = 0; e < 9; e++) begin
      tick(1'b1, 1'b1);
      check($sformatf("bp_pending_e%0d", e), 32'(pending_count), 32'(exp_p[e]));
      check($sformatf("bp_ready_e%0d", e), 32'(inc_ready), 32'(exp_r[e]));
    end
    inc_valid = 1'b0;
    drain();
    check("bp_drained_pending", 32'(pending_count), 32'd0);

    // Wrap: 17 accepted requests walk the full Gray cycle and land on 0001.
    tick(1'b0, 1'b0);
    acc = 0;
    n   = 0;
    while (acc < 17 && n < 300) begin
      if (inc_ready) acc++;
      tick(1'b1, 1'b1);
      n++;
    end
    check("wrap_accepts", 32'(acc), 32'd17);
    inc_valid = 1'b0;
    drain();
    check("wrap_gray", 32'(gray_out), 32'h1);
    check("wrap_binary", 32'(binary_count), 32'h1);
    check("wrap_issues", 32'(iss_cnt), 32'd17);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while holding with three queued requests.
    tick(1'b0, 1'b0);
    for (int e = 0; e < 5; e++) tick(1'b1, 1'b1);
    check("mid_pending_before", 32'(pending_count), 32'd3);
    check("mid_busy_before", 32'({busy, update_strobe}), 32'b11);
    tick(1'b1, 1'b0);
    check("mid_reset_outputs",
          32'({gray_out, binary_count, pending_count, update_strobe, inc_ready, busy}),
          32'({4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0}));
    tick(1'b0, 1'b1);
    check("mid_idle_after_release",
          32'({gray_out, pending_count, update_strobe, busy}), 32'({4'h0, 3'd0, 1'b0, 1'b0}));
    tick(1'b1, 1'b1);
    check("mid_accept", 32'({gray_out, pending_count}), 32'({4'h0, 3'd1}));
    tick(1'b0, 1'b1);
    check("mid_first_issue", 32'({gray_out, update_strobe}), 32'({4'h1, 1'b1}));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
